// File: rtl/wb_commit_rf_if.sv
// Writeback-stage bus: MEM/WB pipeline inputs, GPR read ports, forwarding
// and commit/halt outputs. The slave side is the writeback block; the master
// side is whatever drives the pipeline register (the pipeline or a bench).
interface wb_commit_rf_if #(
   parameter int XLEN     = 64,
   parameter int INST_LEN = 32
);
   logic [XLEN-1:0]     pc_i;
   logic [INST_LEN-1:0] instr_i;
   logic [XLEN-1:0]     alures_i;
   logic [XLEN-1:0]     lsres_i;
   logic [XLEN-1:0]     csrdata_i;
   logic                wben_i;
   logic [4:0]          rs1_addr_i;
   logic [4:0]          rs2_addr_i;

   logic [XLEN-1:0]     rs1_data_o;
   logic [XLEN-1:0]     rs2_data_o;
   logic                wb_we_o;
   logic [4:0]          wb_rd_o;
   logic [XLEN-1:0]     wb_data_o;
   logic                commit_valid_o;
   logic [XLEN-1:0]     commit_pc_o;
   logic [INST_LEN-1:0] commit_instr_o;
   logic [63:0]         instret_o;
   logic                halt_o;
   logic [XLEN-1:0]     exit_code_o;

   modport slave (
      input  pc_i, instr_i, alures_i, lsres_i, csrdata_i, wben_i,
             rs1_addr_i, rs2_addr_i,
      output rs1_data_o, rs2_data_o, wb_we_o, wb_rd_o, wb_data_o,
             commit_valid_o, commit_pc_o, commit_instr_o, instret_o,
             halt_o, exit_code_o
   );

   modport master (
      output pc_i, instr_i, alures_i, lsres_i, csrdata_i, wben_i,
             rs1_addr_i, rs2_addr_i,
      input  rs1_data_o, rs2_data_o, wb_we_o, wb_rd_o, wb_data_o,
             commit_valid_o, commit_pc_o, commit_instr_o, instret_o,
             halt_o, exit_code_o
   );
endinterface

// File: rtl/wb_commit_rf.sv
// Writeback stage: selects the writeback value (ALU / load / CSR), writes the
// GPR file, serves two combinational read ports with write-through bypass,
// and produces the registered commit stream, retired-instruction counter and
// sticky ebreak halt with the exit code taken from x10.
module wb_commit_rf #(
   parameter int XLEN     = 64,
   parameter int INST_LEN = 32,
   parameter int NREG     = 32
) (
   input  logic           clk,
   input  logic           rst,
   wb_commit_rf_if.slave  bus
);

   localparam logic [6:0]          OP_LOAD   = 7'b0000011;
   localparam logic [6:0]          OP_SYSTEM = 7'b1110011;
   localparam logic [INST_LEN-1:0] EBREAK    = INST_LEN'(32'h0010_0073);
   localparam logic [4:0]          X10       = 5'd10;

   logic [XLEN-1:0]     gpr_q [NREG];
   logic                commit_valid_q;
   logic [XLEN-1:0]     commit_pc_q;
   logic [INST_LEN-1:0] commit_instr_q;
   logic [63:0]         instret_q;
   logic                halt_q;
   logic [XLEN-1:0]     exit_code_q;

   logic [6:0]      op;
   logic [2:0]      f3;
   logic [4:0]      rd;
   logic            is_load;
   logic            is_csr;
   logic [XLEN-1:0] wb_data;
   logic            wb_we;
   logic            retire;
   logic            take_halt;
   logic [XLEN-1:0] x10_fwd;

   assign op = bus.instr_i[6:0];
   assign f3 = bus.instr_i[14:12];
   assign rd = bus.instr_i[11:7];

   assign is_load = (op == OP_LOAD);
   assign is_csr  = (op == OP_SYSTEM) && (f3 != 3'd0);

   // Writeback source select: load data wins, then old CSR value, else ALU
   // (which also carries the link address for jal/jalr).
   always_comb begin
      wb_data = bus.alures_i;
      if (is_load) begin
         wb_data = bus.lsres_i;
      end else if (is_csr) begin
         wb_data = bus.csrdata_i;
      end
   end

   // Halted core must not disturb architectural state; x0 is never written.
   assign wb_we     = bus.wben_i && (rd != 5'd0) && !halt_q;
   assign retire    = (bus.instr_i != '0) && !halt_q;
   assign take_halt = (bus.instr_i == EBREAK) && !halt_q;

   // Read ports see this cycle's write before it lands in the array.
   assign bus.rs1_data_o = (bus.rs1_addr_i == 5'd0)                 ? '0      :
                           (wb_we && (rd == bus.rs1_addr_i))        ? wb_data :
                                                                      gpr_q[bus.rs1_addr_i];
   assign bus.rs2_data_o = (bus.rs2_addr_i == 5'd0)                 ? '0      :
                           (wb_we && (rd == bus.rs2_addr_i))        ? wb_data :
                                                                      gpr_q[bus.rs2_addr_i];
   assign x10_fwd        = (wb_we && (rd == X10)) ? wb_data : gpr_q[X10];

   assign bus.wb_we_o        = wb_we;
   assign bus.wb_rd_o        = rd;
   assign bus.wb_data_o      = wb_data;
   assign bus.commit_valid_o = commit_valid_q;
   assign bus.commit_pc_o    = commit_pc_q;
   assign bus.commit_instr_o = commit_instr_q;
   assign bus.instret_o      = instret_q;
   assign bus.halt_o         = halt_q;
   assign bus.exit_code_o    = exit_code_q;

   // GPR array: cleared by reset, written on the edge where the write is effective.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            gpr_q[i] <= '0;
         end
      end else if (wb_we) begin
         gpr_q[rd] <= wb_data;
      end
   end

   // Commit stream and retired-instruction counter; pc/instr track WB every cycle,
   // valid only reflects an actual retire.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         commit_valid_q <= 1'b0;
         commit_pc_q    <= '0;
         commit_instr_q <= '0;
         instret_q      <= '0;
      end else begin
         commit_valid_q <= retire;
         commit_pc_q    <= bus.pc_i;
         commit_instr_q <= bus.instr_i;
         if (retire) begin
            instret_q <= instret_q + 64'd1;
         end
      end
   end

   // Sticky halt on the first ebreak; exit code is x10 as seen through the bypass.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         halt_q      <= 1'b0;
         exit_code_q <= '0;
      end else if (take_halt) begin
         halt_q      <= 1'b1;
         exit_code_q <= x10_fwd;
      end
   end

endmodule

// File: tb/tb_wb_commit_rf.sv
// Bench for wb_commit_rf: directed scenarios plus randomized traffic, checked
// every cycle against an architectural model of the register file, counter,
// commit stream and halt flag.
module tb_wb_commit_rf;
   localparam int XLEN = 64;
   localparam int IL   = 32;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_commit_rf_if #(.XLEN(XLEN), .INST_LEN(IL)) bus ();

   wb_commit_rf #(.XLEN(XLEN), .INST_LEN(IL), .NREG(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk = 0;
   int n_err = 0;

   // architectural model
   logic [63:0] m_gpr [32];
   logic        m_halt;
   logic [63:0] m_instret;
   logic [63:0] m_exit;
   logic        m_cv;
   logic [63:0] m_cpc;
   logic [31:0] m_cinstr;

   function automatic logic [31:0] mk(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd,
                                      input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [63:0] m_wbdata();
      logic [31:0] ins;
      ins = bus.instr_i;
      if (ins[6:0] == 7'b0000011) return bus.lsres_i;
      if (ins[6:0] == 7'b1110011 && ins[14:12] != 3'd0) return bus.csrdata_i;
      return bus.alures_i;
   endfunction

   function automatic logic m_we();
      logic [31:0] ins;
      ins = bus.instr_i;
      return bus.wben_i && (ins[11:7] != 5'd0) && !m_halt;
   endfunction

   function automatic logic [63:0] m_read(input logic [4:0] a);
      logic [31:0] ins;
      ins = bus.instr_i;
      if (a == 5'd0) return 64'd0;
      if (m_we() && ins[11:7] == a) return m_wbdata();
      return m_gpr[a];
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 32; i++) m_gpr[i] = 64'd0;
      m_halt = 1'b0; m_instret = 64'd0; m_exit = 64'd0;
      m_cv = 1'b0; m_cpc = 64'd0; m_cinstr = 32'd0;
   endtask

   task automatic model_update();
      logic        we, ret;
      logic [63:0] d, x10v;
      logic [31:0] ins;
      ins  = bus.instr_i;
      we   = m_we();
      d    = m_wbdata();
      x10v = m_read(5'd10);
      ret  = (ins != 32'd0) && !m_halt;
      if (ins == EBREAK && !m_halt) begin
         m_halt = 1'b1;
         m_exit = x10v;
      end
      if (we) m_gpr[ins[11:7]] = d;
      m_cv     = ret;
      m_cpc    = bus.pc_i;
      m_cinstr = ins;
      if (ret) m_instret = m_instret + 64'd1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("rs1_data", bus.rs1_data_o, m_read(bus.rs1_addr_i));
      chk("rs2_data", bus.rs2_data_o, m_read(bus.rs2_addr_i));
      chk("wb_we", 64'(bus.wb_we_o), 64'(m_we()));
      chk("wb_rd", 64'(bus.wb_rd_o), 64'(bus.instr_i[11:7]));
      chk("wb_data", bus.wb_data_o, m_wbdata());
      chk("commit_valid", 64'(bus.commit_valid_o), 64'(m_cv));
      chk("commit_pc", bus.commit_pc_o, m_cpc);
      chk("commit_instr", 64'(bus.commit_instr_o), 64'(m_cinstr));
      chk("instret", bus.instret_o, m_instret);
      chk("halt", 64'(bus.halt_o), 64'(m_halt));
      chk("exit_code", bus.exit_code_o, m_exit);
   endtask

   task automatic half_a();
      @(negedge clk);
      check_all();
   endtask

   task automatic half_b();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic step();
      half_a();
      half_b();
   endtask

   task automatic drive(input logic [63:0] pc, input logic [31:0] ins, input logic [63:0] alu,
                        input logic [63:0] ls, input logic [63:0] csr, input logic wben,
                        input logic [4:0] a1, input logic [4:0] a2);
      bus.pc_i = pc; bus.instr_i = ins; bus.alures_i = alu; bus.lsres_i = ls;
      bus.csrdata_i = csr; bus.wben_i = wben; bus.rs1_addr_i = a1; bus.rs2_addr_i = a2;
   endtask

   task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
      drive(64'd0, 32'd0, 64'd0, 64'd0, 64'd0, 1'b0, a1, a2);
   endtask

   task automatic apply_reset();
      idle(5'd6, 5'd10);
      rst = 1'b1;
      #1;
      m_reset();
      check_all();
      chk("rst_commit_valid", 64'(bus.commit_valid_o), 64'd0);
      chk("rst_instret", bus.instret_o, 64'd0);
      chk("rst_halt", 64'(bus.halt_o), 64'd0);
      chk("rst_rs1_x6", bus.rs1_data_o, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic rand_cycle();
      logic [31:0] ins;
      logic [4:0]  rd, a1, a2;
      logic        wben;
      int          kind;
      kind = $urandom_range(0, 4);
      rd   = 5'($urandom_range(0, 31));
      wben = 1'($urandom_range(0, 1));
      case (kind)
         0: begin ins = 32'd0; wben = 1'b0; end
         1: ins = mk(12'($urandom), 5'($urandom), 3'($urandom), rd, 7'b0000011);
         2: ins = mk(12'($urandom), 5'($urandom), 3'($urandom), rd, 7'b1110011);
         3: ins = mk(12'($urandom), 5'($urandom), 3'd0, rd, 7'b0010011);
         default: ins = $urandom;
      endcase
      if (ins == EBREAK) ins = 32'h0000_0013;
      a1 = ($urandom_range(0, 2) == 0) ? ins[11:7] : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 2) == 0) ? ins[11:7] : 5'($urandom_range(0, 31));
      drive({$urandom, $urandom}, ins, {$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom}, wben, a1, a2);
      step();
   endtask

   logic [63:0] saved_instret;

   initial begin
      rst = 1'b1;
      apply_reset();

      // every register reads zero after reset
      for (int i = 1; i < 32; i++) begin
         idle(5'(i), 5'(31 - i + 1));
         half_a();
         chk("post_reset_read", bus.rs1_data_o, 64'd0);
         half_b();
      end

      // addi x5 with same-cycle bypass
      drive(64'h100, 32'h00A0_0293, 64'hA, 64'h0, 64'h0, 1'b1, 5'd5, 5'd0);
      half_a();
      chk("bypass_x5", bus.rs1_data_o, 64'hA);
      half_b();
      idle(5'd5, 5'd5);
      half_a();
      chk("array_x5", bus.rs1_data_o, 64'hA);
      chk("commit_valid_addi", 64'(bus.commit_valid_o), 64'd1);
      chk("commit_pc_addi", bus.commit_pc_o, 64'h100);
      chk("instret_addi", bus.instret_o, 64'd1);
      half_b();

      // load, CSR, CSR to x0
      drive(64'h104, mk(12'h0, 5'd1, 3'b010, 5'd6, 7'b0000011), 64'h1234, 64'hDEAD, 64'h0, 1'b1, 5'd0, 5'd0);
      step();
      drive(64'h108, mk(12'h300, 5'd1, 3'b001, 5'd7, 7'b1110011), 64'h99, 64'h0, 64'h55, 1'b1, 5'd0, 5'd0);
      step();
      drive(64'h10C, mk(12'h300, 5'd1, 3'b001, 5'd0, 7'b1110011), 64'h99, 64'h0, 64'h66, 1'b1, 5'd0, 5'd0);
      step();
      idle(5'd6, 5'd7);
      half_a();
      chk("load_x6", bus.rs1_data_o, 64'hDEAD);
      chk("csr_x7", bus.rs2_data_o, 64'h55);
      half_b();

      // write to x0 is suppressed
      drive(64'h110, 32'h0FF0_0013, 64'hFF, 64'h0, 64'h0, 1'b1, 5'd0, 5'd0);
      half_a();
      chk("x0_we", 64'(bus.wb_we_o), 64'd0);
      chk("x0_read", bus.rs1_data_o, 64'd0);
      half_b();
      idle(5'd0, 5'd0);
      step();
      saved_instret = m_instret;
      step();
      step();
      half_a();
      chk("bubble_valid", 64'(bus.commit_valid_o), 64'd0);
      chk("bubble_instret", bus.instret_o, 64'd5);
      chk("bubble_instret_model", saved_instret, 64'd5);
      half_b();

      for (int i = 0; i < 400; i++) rand_cycle();

      // counter wrap
      force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.instret_q;
      m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
      drive(64'h200, 32'h0000_0013, 64'h0, 64'h0, 64'h0, 1'b0, 5'd0, 5'd0);
      step();
      idle(5'd0, 5'd0);
      half_a();
      chk("instret_wrap", bus.instret_o, 64'd0);
      half_b();

      // reset mid-stream, then halt with x10 = 0
      apply_reset();
      drive(64'h300, mk(12'h0, 5'd0, 3'd0, 5'd10, 7'b0010011), 64'h0, 64'h0, 64'h0, 1'b1, 5'd0, 5'd0);
      step();
      drive(64'h304, EBREAK, 64'h0, 64'h0, 64'h0, 1'b0, 5'd10, 5'd0);
      step();
      drive(64'h308, mk(12'h7, 5'd0, 3'd0, 5'd10, 7'b0010011), 64'h7, 64'h0, 64'h0, 1'b1, 5'd10, 5'd0);
      half_a();
      chk("halt_set", 64'(bus.halt_o), 64'd1);
      chk("halt_exit0", bus.exit_code_o, 64'd0);
      chk("halt_instret", bus.instret_o, 64'd2);
      chk("halt_commit_ebreak", 64'(bus.commit_valid_o), 64'd1);
      chk("halt_no_we", 64'(bus.wb_we_o), 64'd0);
      half_b();
      idle(5'd10, 5'd10);
      half_a();
      chk("halted_no_commit", 64'(bus.commit_valid_o), 64'd0);
      chk("halted_x10", bus.rs1_data_o, 64'd0);
      chk("halted_instret", bus.instret_o, 64'd2);
      half_b();

      // second run: nonzero exit code, second ebreak ignored
      apply_reset();
      drive(64'h400, mk(12'h77, 5'd0, 3'd0, 5'd10, 7'b0010011), 64'h77, 64'h0, 64'h0, 1'b1, 5'd0, 5'd0);
      step();
      drive(64'h404, EBREAK, 64'h0, 64'h0, 64'h0, 1'b0, 5'd10, 5'd0);
      step();
      drive(64'h408, mk(12'h0, 5'd0, 3'd0, 5'd10, 7'b0010011), 64'h5, 64'h0, 64'h0, 1'b1, 5'd0, 5'd0);
      step();
      drive(64'h40C, EBREAK, 64'h0, 64'h0, 64'h0, 1'b0, 5'd10, 5'd0);
      step();
      idle(5'd10, 5'd0);
      half_a();
      chk("exit_x77", bus.exit_code_o, 64'h77);
      chk("exit_instret", bus.instret_o, 64'd2);
      chk("exit_x10_kept", bus.rs1_data_o, 64'h77);
      half_b();
      for (int i = 0; i < 40; i++) rand_cycle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
